// File: rtl/speech_pkg.sv
// Shared types for the speech-session controller and the comparison engine.
// Session state encoding appears on led[7:5], so its values are fixed.
package speech_pkg;
  localparam int SPI_BITS = 8;
  localparam int RES_W    = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    PROC    = 3'd2,
    WAIT_TX = 3'd3,
    SEND    = 3'd4
  } sess_state_t;
endpackage

// File: rtl/spi_oversampler.sv
// Brings the SPI pins into the clk domain, detects edges and shifts rx/tx bits (mode 0, MSB first).
// With SPEECH_TIMEOUT_EN defined an sck-activity strobe is exported for the session watchdog.
module spi_oversampler
  import speech_pkg::*;
#(
  parameter int SYNC_STAGES = 2
)(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_sck,
  input  logic                i_sdi,
  input  logic                i_ss,
  input  logic                i_rx_en,
  input  logic                i_tx_arm,
  input  logic                i_tx_en,
  input  logic [SPI_BITS-1:0] i_tx_byte,
  output logic                o_byte_valid,
  output logic [SPI_BITS-1:0] o_rx_byte,
  output logic                o_tx_load,
  output logic                o_tx_done,
  output logic                o_ss_rise,
  output logic                o_ss_fall,
`ifdef SPEECH_TIMEOUT_EN
  output logic                o_sck_edge,
`endif
  output logic                o_tx_bit
);
  localparam int CW = $clog2(SPI_BITS);

  logic [SYNC_STAGES-1:0] r_sck_sync, r_sdi_sync, r_ss_sync;
  logic                   r_sck_q, r_ss_q;
  logic [CW-1:0]          r_bit_cnt;
  logic [SPI_BITS-2:0]    r_rx_sr;
  logic [SPI_BITS-1:0]    r_rx_byte, r_tx_sr;
  logic                   r_byte_valid;
  logic w_sck, w_sdi, w_ss, w_sck_rise, w_sck_fall, w_frame, w_last_bit, w_rx_shift;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
  assign w_ss       = r_ss_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_q;
  assign w_sck_fall = ~w_sck & r_sck_q;
  assign o_ss_rise  = w_ss & ~r_ss_q;
  assign o_ss_fall  = ~w_ss & r_ss_q;
  // A final bit that lands in the same clk as the ss fall still completes its byte.
  assign w_frame    = w_ss | o_ss_fall;
  assign w_last_bit = (r_bit_cnt == CW'(SPI_BITS - 1));
  assign w_rx_shift = i_rx_en & w_frame & w_sck_rise;

  assign o_tx_load    = i_tx_arm & o_ss_rise;
  assign o_tx_done    = i_tx_en & w_ss & w_sck_rise & w_last_bit;
  assign o_tx_bit     = r_tx_sr[SPI_BITS-1];
  assign o_byte_valid = r_byte_valid;
  assign o_rx_byte    = r_rx_byte;
`ifdef SPEECH_TIMEOUT_EN
  assign o_sck_edge   = w_sck_rise | w_sck_fall;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sck_sync   <= '0;
      r_sdi_sync   <= '0;
      r_ss_sync    <= '0;
      r_sck_q      <= 1'b0;
      r_ss_q       <= 1'b0;
      r_bit_cnt    <= '0;
      r_rx_sr      <= '0;
      r_rx_byte    <= '0;
      r_tx_sr      <= '0;
      r_byte_valid <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], i_sdi};
      r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
      r_sck_q    <= w_sck;
      r_ss_q     <= w_ss;

      if (!((i_rx_en | i_tx_en) & w_ss)) r_bit_cnt <= '0;
      else if (w_sck_rise)                r_bit_cnt <= r_bit_cnt + 1'b1;

      r_byte_valid <= w_rx_shift & w_last_bit;
      if (w_rx_shift) begin
        r_rx_sr <= {r_rx_sr[SPI_BITS-3:0], w_sdi};
        if (w_last_bit) r_rx_byte <= {r_rx_sr, w_sdi};
      end

      if (o_tx_load)                        r_tx_sr <= i_tx_byte;
      else if (i_tx_en & w_ss & w_sck_fall) r_tx_sr <= {r_tx_sr[SPI_BITS-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/speech_session_ctrl.sv
// Session sequencer: SPI capture into sample RAM, comparison handshake, result readback.
// Optional RECV watchdog enabled by defining SPEECH_TIMEOUT_EN.
//   state   | meaning
//   IDLE    | no session, waiting for ss rise
//   RECV    | capturing audio bytes into sample RAM
//   PROC    | comparison engine running
//   WAIT_TX | result latched, waiting for master frame
//   SEND    | shifting {4'h0,result} out on sdo
module speech_session_ctrl
  import speech_pkg::*;
#(
  parameter int NSAMPLES    = 2000,
  parameter int AW          = 11,
  parameter int SYNC_STAGES = 2
`ifdef SPEECH_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 2**20
`endif
)(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_sck,
  input  logic             i_sdi,
  input  logic             i_ss,
  output logic             o_sdo,
  output logic             o_mem_we,
  output logic [AW-1:0]    o_mem_addr,
  output logic [7:0]       o_mem_wdata,
  output logic             o_cmp_start,
  input  logic             i_cmp_done,
  input  logic [RES_W-1:0] i_cmp_result,
  output logic [RES_W-1:0] o_result,
  output logic [7:0]       o_led,
  output logic             o_busy
);
  sess_state_t         r_state, w_state_nxt;
  logic [AW-1:0]       r_idx, r_mem_addr;
  logic [7:0]          r_mem_wdata;
  logic                r_mem_we, r_cmp_start;
  logic [RES_W-1:0]    r_result;
  logic [SPI_BITS-1:0] w_rx_byte;
  logic w_byte_valid, w_tx_load, w_tx_done, w_tx_bit, w_ss_rise, w_ss_fall;
  logic w_timeout, w_timeout_flag, w_last_write, w_cmp_take;
`ifdef SPEECH_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC) + 1;
  logic [WDW-1:0] r_wdog;
  logic           r_timeout_flag, w_sck_edge;
`endif

  spi_oversampler #(.SYNC_STAGES(SYNC_STAGES)) u_spi (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_sck        (i_sck),
    .i_sdi        (i_sdi),
    .i_ss         (i_ss),
    .i_rx_en      (r_state == RECV),
    .i_tx_arm     (r_state == WAIT_TX),
    .i_tx_en      (r_state == SEND),
    .i_tx_byte    ({{(SPI_BITS-RES_W){1'b0}}, r_result}),
    .o_byte_valid (w_byte_valid),
    .o_rx_byte    (w_rx_byte),
    .o_tx_load    (w_tx_load),
    .o_tx_done    (w_tx_done),
    .o_ss_rise    (w_ss_rise),
    .o_ss_fall    (w_ss_fall),
`ifdef SPEECH_TIMEOUT_EN
    .o_sck_edge   (w_sck_edge),
`endif
    .o_tx_bit     (w_tx_bit)
  );

  // Leave RECV only after the final write is on the bus, so the engine never races it.
  assign w_last_write = r_mem_we & (r_mem_addr == AW'(NSAMPLES - 1));
  assign w_cmp_take   = (r_state == PROC) & i_cmp_done & ~r_cmp_start;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_ss_rise) w_state_nxt = RECV;
      RECV:    if (w_timeout) w_state_nxt = IDLE;
               else if (w_last_write) w_state_nxt = PROC;
      PROC:    if (w_cmp_take) w_state_nxt = WAIT_TX;
      WAIT_TX: if (w_tx_load) w_state_nxt = SEND;
      SEND:    if (w_ss_fall) w_state_nxt = WAIT_TX;
               else if (w_tx_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cmp_start <= 1'b0;
      r_result    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mem_we <= w_byte_valid & (r_state == RECV);
      if (w_byte_valid && r_state == RECV) begin
        r_mem_wdata <= w_rx_byte;
        r_mem_addr  <= r_idx;
        r_idx       <= r_idx + 1'b1;
      end
      if (w_state_nxt == IDLE) r_idx <= '0;
      r_cmp_start <= (r_state == RECV) && (w_state_nxt == PROC);
      if (w_cmp_take) r_result <= i_cmp_result;
    end
  end

`ifdef SPEECH_TIMEOUT_EN
  assign w_timeout      = (r_state == RECV) && (r_wdog == '0);
  assign w_timeout_flag = r_timeout_flag;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wdog         <= WDW'(TIMEOUT_CYC - 1);
      r_timeout_flag <= 1'b0;
    end else begin
      if (r_state != RECV || w_sck_edge) r_wdog <= WDW'(TIMEOUT_CYC - 1);
      else if (r_wdog != '0)             r_wdog <= r_wdog - 1'b1;
      if (w_ss_rise)      r_timeout_flag <= 1'b0;
      else if (w_timeout) r_timeout_flag <= 1'b1;
    end
  end
`else
  assign w_timeout      = 1'b0;
  assign w_timeout_flag = 1'b0;
`endif

  assign o_sdo       = (r_state == SEND) & w_tx_bit;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_cmp_start = r_cmp_start;
  assign o_result    = r_result;
  assign o_led       = {r_state, w_timeout_flag, r_result};
  assign o_busy      = (r_state != IDLE);
endmodule
